// File: rtl/button_debouncer.sv
// Per-button 2-flop synchronizer, consecutive-sample debouncer and press pulse.
// Define BTN_REPEAT_EN to compile in hold-to-repeat pulses.
module button_debouncer #(
    parameter int NBTN            = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
        $error("button_debouncer: illegal parameter set");
    end

    logic [NBTN-1:0] s1_q;
    logic [NBTN-1:0] s2_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_e;
`endif

    for (genvar i = 0; i < NBTN; i++) begin : g_ch
        logic [DW-1:0] cnt_q;
        logic [DW-1:0] cnt_d;
        logic          level_q;
        logic          level_d;
        logic          pulse_q;
        logic          pulse_d;
        logic          rise;

        always_comb begin
            cnt_d   = '0;
            level_d = level_q;
            if (s2_q[i] != level_q) begin
                if (cnt_q == DB_LAST) begin
                    level_d = s2_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        assign rise = level_d & ~level_q;

`ifdef BTN_REPEAT_EN
        state_e        state_q;
        state_e        state_d;
        logic [RW-1:0] rcnt_q;
        logic [RW-1:0] rcnt_d;
        logic          fall;
        logic          rpt;

        assign fall = level_q & ~level_d;

        // An accepted release always beats a repeat due on the same edge.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            rpt     = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = DELAY;
                        rcnt_d  = '0;
                    end
                end
                DELAY: begin
                    if (fall) begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RD_LAST) begin
                        state_d = REPEAT;
                        rcnt_d  = '0;
                        rpt     = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == RP_LAST) begin
                        rcnt_d = '0;
                        rpt    = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
            end
        end

        assign pulse_d = rise | rpt;
`else
        assign pulse_d = rise;
`endif

        always_ff @(posedge CLK) begin
            if (RESET) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
            end
        end

        assign btn_level[i] = level_q;
        assign btn_pulse[i] = pulse_q;
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: table-driven rows, hand-written corner sequences,
// and a per-cycle scoreboard fed by a window-based reference model.
module tb_button_debouncer;

    localparam int NB = 3;
    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef BTN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic          CLK;
    logic          RESET;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;

    button_debouncer #(
        .NBTN           (NB),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [NB-1:0] raw;
        int            cycles;
        logic [NB-1:0] lvl;
        int            pulses;
    } vec_t;

    typedef struct {
        logic [NB-1:0] lvl;
        logic [NB-1:0] pul;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    logic [NB-1:0] m_s1;
    logic [NB-1:0] m_s2;
    logic [NB-1:0] m_lvl;
    logic [DC-1:0] hist[NB];
    int            last_flip[NB];
    int            age[NB];
    bit            act[NB];
    int            edge_n = 0;

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Drive one cycle, predict the outputs after the coming edge, then compare.
    task automatic tick(input logic [NB-1:0] raw, input logic rst);
        logic [NB-1:0] nl;
        logic [NB-1:0] ep;
        exp_t          e;
        btn_raw = raw;
        RESET   = rst;
        edge_n++;
        ep = '0;
        if (rst) begin
            m_s1  = '0;
            m_s2  = '0;
            m_lvl = '0;
            for (int i = 0; i < NB; i++) begin
                hist[i]      = '0;
                last_flip[i] = edge_n;
                act[i]       = 1'b0;
                age[i]       = 0;
            end
        end else begin
            nl = m_lvl;
            for (int i = 0; i < NB; i++) begin
                hist[i] = {hist[i][DC-2:0], m_s2[i]};
                if ((edge_n - last_flip[i] >= DC) && (hist[i] == {DC{~m_lvl[i]}})) begin
                    nl[i]        = ~m_lvl[i];
                    last_flip[i] = edge_n;
                end
                if (nl[i] && !m_lvl[i]) begin
                    ep[i]  = 1'b1;
                    act[i] = 1'b1;
                    age[i] = 0;
                end else if (!nl[i]) begin
                    act[i] = 1'b0;
                end else if (act[i]) begin
                    age[i]++;
                    if (REP && (age[i] == RD || (age[i] > RD && (age[i] - RD) % RP == 0)))
                        ep[i] = 1'b1;
                end
            end
            m_lvl = nl;
            m_s2  = m_s1;
            m_s1  = raw;
        end
        e.lvl = m_lvl;
        e.pul = ep;
        exp_q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        e = exp_q.pop_front();
        chk($sformatf("sb level e%0d", edge_n), int'(btn_level), int'(e.lvl));
        chk($sformatf("sb pulse e%0d", edge_n), int'(btn_pulse), int'(e.pul));
    endtask

    vec_t tbl[16];

    initial begin
        int first;
        int second;
        int last;
        int cnt;
        int fidx;
        int pfall;

        tbl = '{
            '{3'b001, 8, 3'b001, 1},
            '{3'b000, 8, 3'b000, 0},
            '{3'b010, 3, 3'b000, 0},
            '{3'b000, 1, 3'b000, 0},
            '{3'b010, 3, 3'b000, 0},
            '{3'b000, 8, 3'b000, 0},
            '{3'b011, 8, 3'b011, 2},
            '{3'b000, 8, 3'b000, 0},
            '{3'b100, 8, 3'b100, 1},
            '{3'b000, 8, 3'b000, 0},
            '{3'b111, 8, 3'b111, 3},
            '{3'b000, 8, 3'b000, 0},
            '{3'b001, 6, 3'b001, 1},
            '{3'b000, 2, 3'b001, 0},
            '{3'b001, 2, 3'b001, 0},
            '{3'b000, 8, 3'b000, 0}
        };

        RESET   = 1'b1;
        btn_raw = '0;
        @(negedge CLK);
        tick('0, 1'b1);
        tick('0, 1'b1);
        chk("reset level", int'(btn_level), 0);
        chk("reset pulse", int'(btn_pulse), 0);

        for (int r = 0; r < 16; r++) begin
            cnt = 0;
            for (int c = 0; c < tbl[r].cycles; c++) begin
                tick(tbl[r].raw, 1'b0);
                cnt += $countones(btn_pulse);
            end
            chk($sformatf("row%0d level", r), int'(btn_level), int'(tbl[r].lvl));
            chk($sformatf("row%0d pulses", r), cnt, tbl[r].pulses);
        end

        // Clean press on bit 0: exact latency and pulse width
        first = -1;
        cnt   = 0;
        for (int t = 0; t < 20; t++) begin
            tick(3'b001, 1'b0);
            if (t == 4) chk("A level before accept", int'(btn_level[0]), 0);
            if (t == 6) chk("A pulse width", int'(btn_pulse[0]), 0);
            if (btn_pulse[0]) begin
                cnt++;
                if (first < 0) first = t;
            end
        end
        chk("A press index", first, 5);
        chk("A hold pulses", cnt, REP ? 3 : 1);
        fidx  = -1;
        cnt   = 0;
        pfall = -1;
        for (int t = 0; t < 8; t++) begin
            tick(3'b000, 1'b0);
            if (fidx < 0 && !btn_level[0]) begin
                fidx  = t;
                pfall = int'(btn_pulse[0]);
            end else if (btn_pulse[0]) begin
                cnt++;
            end
        end
        chk("A fall index", fidx, 5);
        chk("A pulse on fall", pfall, 0);
        chk("A drop pulses", cnt, REP ? 2 : 0);

        // Long hold on bit 2, released so the fall lands on a due repeat
        first = -1;
        last  = -1;
        cnt   = 0;
        for (int t = 0; t < 37; t++) begin
            tick(3'b100, 1'b0);
            if (btn_pulse[2]) begin
                cnt++;
                last = t;
                if (first < 0) first = t;
            end
        end
        chk("B press index", first, 5);
        chk("B hold pulses", cnt, REP ? 9 : 1);
        chk("B last pulse index", last, REP ? 36 : 5);
        fidx  = -1;
        cnt   = 0;
        pfall = -1;
        for (int t = 0; t < 10; t++) begin
            tick(3'b000, 1'b0);
            if (fidx < 0 && !btn_level[2]) begin
                fidx  = t;
                pfall = int'(btn_pulse[2]);
            end else if (btn_pulse[2]) begin
                cnt++;
            end
        end
        chk("B fall index", fidx, 5);
        chk("B release beats repeat", pfall, 0);
        chk("B drop pulses", cnt, REP ? 1 : 0);

        // Reset while held in the repeat phase
        for (int t = 0; t < 18; t++) tick(3'b001, 1'b0);
        chk("C level held", int'(btn_level), 1);
        for (int t = 0; t < 2; t++) begin
            tick(3'b001, 1'b1);
            chk($sformatf("C reset level %0d", t), int'(btn_level), 0);
            chk($sformatf("C reset pulse %0d", t), int'(btn_pulse), 0);
        end
        first  = -1;
        second = -1;
        cnt    = 0;
        for (int t = 0; t < 20; t++) begin
            tick(3'b001, 1'b0);
            if (btn_pulse[0]) begin
                cnt++;
                if (first < 0) first = t;
                else if (second < 0) second = t;
            end
        end
        chk("C repress index", first, 5);
        chk("C first repeat index", second, REP ? 15 : -1);
        chk("C post-reset pulses", cnt, REP ? 3 : 1);
        for (int t = 0; t < 8; t++) tick(3'b000, 1'b0);
        chk("C final level", int'(btn_level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions the three raw push-button inputs (Right, Up, Down) before they reach the cursor tracker stage. Each channel passes through a two-flop synchronizer and a consecutive-sample debouncer, and produces a clean level plus a one-cycle press pulse. The pulse vector drives the tracker's `PushButton` input, which is edge-sensitive, so each pulse moves the cursor by exactly one step. An optional auto-repeat feature emits further pulses while a button is held.

## Interface
- `NBTN`, default 3: number of button channels; bit 0 = Right, bit 1 = Up, bit 2 = Down.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronized samples needed to accept a level change. Must be ≥ 1.
- `REPEAT_DELAY`, default 50_000_000: cycles from a press pulse to the first repeat pulse. Must be ≥ 2.
- `REPEAT_PERIOD`, default 10_000_000: cycles between successive repeat pulses. Must be ≥ 2.
- `CLK`, input, 1: the single clock; all logic is on its rising edge.
- `RESET`, input, 1: synchronous, active-high reset.
- `btn_raw`, input, NBTN: asynchronous raw button levels, active-high.
- `btn_level`, output, NBTN: debounced level per channel, registered.
- `btn_pulse`, output, NBTN: one-cycle pulse per accepted press, plus repeat pulses when enabled; registered.

## Operation
- **Synchronizer:** two flops per channel, `s1 <= btn_raw` then `s2 <= s1`. Both are cleared by `RESET`.
- **Debounce counter:** one per channel, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s2 == btn_level`, the counter clears to 0.
  - Otherwise it increments.
  - At the edge where the counter equals `DEBOUNCE_CYCLES-1` while still mismatched, `btn_level <= s2` and the counter clears.
- **Press pulse:** `btn_pulse[i]` is 1 for exactly the cycle after `btn_level[i]` rises (registered together with the level update). A falling `btn_level` never pulses.
- **Per-channel state machine** (repeat feature compiled in):
  - IDLE, with `btn_level=0`: goes to DELAY on an accepted rise, emitting the press pulse and loading the repeat counter with 0.
  - DELAY: the counter increments each cycle. When it reaches `REPEAT_DELAY-1`, emit a pulse, clear the counter, and go to REPEAT.
  - REPEAT: the counter increments. When it reaches `REPEAT_PERIOD-1`, emit a pulse and clear the counter.
  - From DELAY or REPEAT, an accepted fall returns the channel to IDLE and clears the counter. No pulse is emitted in the fall cycle.
- **Channel independence:** channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses. The downstream tracker resolves priority (Right > Up > Down).
- **Glitch rejection:** a bounce of any length shorter than `DEBOUNCE_CYCLES` samples clears the counter and produces no level change.
- **Pulse spacing:** pulses are always separated by at least one low cycle, because `REPEAT_PERIOD` ≥ 2. The downstream rising-edge detector therefore sees every pulse.

## Timing
- **Reset values:** `btn_level=0`, `btn_pulse=0`, synchronizer flops 0, all counters 0, state IDLE.
- **Reset mid-operation:** a held button with `RESET` asserted leaves `btn_level=0`. After reset releases, the press is re-debounced and re-pulsed normally.
- **Latency:** let the edge that first captures a new `btn_raw` value into `s1` be edge 0. Then `s2` holds the new value after edge 1, and `btn_level` and `btn_pulse` update at edge `DEBOUNCE_CYCLES+1`.
- **Press-pulse width:** exactly 1 cycle.
- **Repeat timing:** the first repeat pulse comes `REPEAT_DELAY` cycles after the press pulse. Subsequent repeat pulses come every `REPEAT_PERIOD` cycles.
- **Release during DELAY or REPEAT:**
  - A release accepted on the same edge a repeat pulse would fire suppresses that pulse.
  - Release wins over repeat.

## Configuration
- **Macro:** `BTN_REPEAT_EN`.
- **With the macro defined:** the DELAY/REPEAT states and the repeat counter exist, and auto-repeat behaves as described above.
- **Without the macro:**
  - The repeat counter and the DELAY/REPEAT states are not compiled.
  - `btn_pulse` carries only the single press pulse per accepted rise.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=3`.

1. **Clean press and release on bit 0:** raise `btn_raw[0]` and hold it 20 cycles, then drop it. Required: `btn_level[0]` rises 5 edges after first capture, with a single 1-cycle `btn_pulse[0]` alongside it, and falls 5 edges after the drop with no pulse.
2. **Bounce rejection on bit 1:** toggle `btn_raw[1]` high 3 cycles, low 1 cycle, high 3 cycles, then low. Required: `btn_level[1]` and `btn_pulse[1]` stay 0 throughout.
3. **Auto-repeat, macro defined:** hold `btn_raw[2]` for 30 cycles after acceptance. Required: the press pulse at cycle P, repeat pulses at P+10, P+13, P+16, and so on, with no pulse after the release is accepted.
4. **No repeat, macro undefined:** same stimulus as scenario 3. Required: exactly one pulse at P.
5. **Simultaneous press:** raise `btn_raw=3'b011` on the same edge. Required: `btn_pulse=3'b011` for one cycle and `btn_level=3'b011`.
6. **Reset while held:** assert `RESET` for 2 cycles while `btn_level[0]=1` and in REPEAT, with `btn_raw[0]` still high. Required: all outputs 0 during reset. After release, a new press pulse arrives 5 edges later and the first repeat comes 10 cycles after that.
